adc_mv_bcd_conv: RTL
====================

Name: adc_mv_bcd_conv

Overview:
- Sequential converter between the XADC auxiliary-channel result and the 4-digit seven-segment display driver.
- Takes a 16-bit XADC conversion word with a valid strobe and scales its 12-bit code to millivolts: mv = floor(code * FULL_SCALE_MV / 4096).
- Converts the millivolt value to 4 packed BCD digits for the display data_in bus.
- Uses a shift-add multiplier and a double-dabble loop instead of combinational dividers.

Parameters:
- FULL_SCALE_MV, 3000: millivolts for a code of 4096. Legal range 1..9999; guarantees mv <= 9999 and no saturation logic.

Ports:
- clk  input  1  system clock (same domain as DCLK feeding the display)
- RESET  input  1  asynchronous, active-high reset
- adc_data  input  16  XADC result word; code = adc_data[15:4], bits [3:0] ignored
- adc_valid  input  1  one-cycle strobe (EOC-qualified) marking adc_data valid
- adc_ready  output  1  high when a sample can be accepted (state IDLE)
- busy  output  1  high while a conversion is in progress (state != IDLE)
- bcd  output  16  {thousands, hundreds, tens, units}, 4 bits each
- bcd_valid  output  1  one-cycle pulse when bcd has just been updated

Behaviour:
- Reset (async, RESET=1): state=IDLE; bcd=16'h0000; bcd_valid=0; busy=0; adc_ready=1; internal accumulators and counters cleared. Any conversion in flight is abandoned and no bcd_valid is produced for it.
- States: IDLE -> MUL -> DABBLE -> DONE -> IDLE.
- IDLE: on adc_valid=1, latch code=adc_data[15:4], clear the 26-bit accumulator, load the multiplier, go to MUL. Call the accept cycle T.
- MUL: cycles T+1..T+12 (4-bit counter, 12 iterations).
  - Each cycle, if the current code bit (LSB first) is 1, add (FULL_SCALE_MV << i) to the accumulator.
  - After 12 cycles, mv = acc[25:12], 14 bits, truncating.
- DABBLE: cycles T+13..T+26 (14 iterations).
  - Each cycle, add 3 to every BCD nibble >= 5.
  - Then shift {bcd_shift[15:0], mv[13:0]} left by 1.
- DONE: cycle T+27. bcd <= bcd_shift; bcd_valid=1 for this cycle only; next state IDLE.
- Fixed latency: accept in cycle T gives bcd_valid in T+27. Next accept is possible in T+28.
- bcd holds its last value between conversions; the display never sees intermediate digits.
- adc_valid while busy: sample dropped (see the optional feature for the alternative). adc_valid in DONE is also dropped because adc_ready=0.
- Arithmetic widths: code 12 bits unsigned; FULL_SCALE_MV 14 bits; acc 26 bits; no overflow is possible for legal parameters.
- Boundaries:
  - code=0 gives 16'h0000.
  - code=4095 gives floor(4095*FS/4096) = FS-1 when FS <= 4096.
- RESET asserted mid-MUL or mid-DABBLE: immediate return to IDLE; bcd and bcd_valid go to their reset values.

Optional Feature:
- Macro: ADC_MV_BCD_PEND_EN.
- Defined:
  - A one-deep pending register captures the most recent adc_data whose adc_valid arrives while busy. A later sample overwrites an earlier pending one.
  - In DONE with pending set, the next state is MUL directly (pending code loaded, pending cleared). The DONE cycle counts as the accept cycle T' for the pending sample, so its bcd_valid lands in T'+27.
  - adc_ready stays 1 in all states.
- Not defined: samples arriving while busy are lost, and adc_ready = (state==IDLE).

Decomposition:
- Shared package adc_disp_pkg holds:
  - state encoding constants (IDLE, MUL, DABBLE, DONE)
  - CODE_W=12, MV_W=14, BCD_W=16, ACC_W=26
  - MUL_CYCLES=12, DAB_CYCLES=14
- Sub-module bcd_add3: purely combinational nibble correction (in >= 5 ? in+3 : in). Instantiated 4 times in the DABBLE datapath.

Test Plan:
- Reset, then adc_data=16'hE3E0 with a 1-cycle adc_valid -> bcd_valid exactly 27 cycles later, bcd=16'h2670; busy high for cycles T+1..T+27.
- adc_data=16'hFFF0 -> bcd=16'h2999. adc_data=16'h0000 -> bcd=16'h0000. Between conversions, bcd holds the prior value.
- Second adc_valid (16'h8000) issued at T+5 during a conversion of 16'hE3E0:
  - macro off: only bcd=16'h2670 produced; no second bcd_valid.
  - macro on: second result bcd=16'h1500 with bcd_valid at T+54.
- RESET pulsed at T+15 mid-conversion -> bcd=16'h0000 and bcd_valid=0 with no clock edge; no stale bcd_valid afterwards. A fresh sample then converts normally.
- FULL_SCALE_MV=3300, adc_data=16'hFFF0 -> bcd=16'h3299. adc_data=16'h8000 -> bcd=16'h1650.
- Back-to-back accepts at T and T+28 (16'h1000, 16'h2000) -> bcd=16'h0187 at T+27, then 16'h0375 at T+55.

Source files
------------

// File: rtl/adc_disp_pkg.sv
// rtl/adc_disp_pkg.sv - shared widths, iteration counts and state encoding for the ADC-to-BCD path
package adc_disp_pkg;

    localparam int CODE_W     = 12;
    localparam int MV_W       = 14;
    localparam int BCD_W      = 16;
    localparam int ACC_W      = 26;
    localparam int MUL_CYCLES = 12;
    localparam int DAB_CYCLES = 14;
    localparam int CNT_W      = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MUL    = 2'd1,
        DABBLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/bcd_add3.sv
// rtl/bcd_add3.sv - double-dabble nibble correction: add 3 to any digit of 5 or more
module bcd_add3 (
    input  logic [3:0] in,
    output logic [3:0] out
);

    assign out = (in >= 4'd5) ? in + 4'd3 : in;

endmodule

// File: rtl/adc_mv_bcd_conv.sv
// rtl/adc_mv_bcd_conv.sv - XADC code to millivolts to packed BCD; ADC_MV_BCD_PEND_EN adds a one-deep pending sample
module adc_mv_bcd_conv
    import adc_disp_pkg::*;
#(
    parameter int FULL_SCALE_MV = 3000
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic [15:0]      adc_data,
    input  logic             adc_valid,
    output logic             adc_ready,
    output logic             busy,
    output logic [BCD_W-1:0] bcd,
    output logic             bcd_valid
);

    localparam logic [ACC_W-1:0] FS_ACC = ACC_W'(FULL_SCALE_MV);

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [CODE_W-1:0]      code_q, code_d;
    logic [ACC_W-1:0]       mcand_q, mcand_d;
    logic [ACC_W-1:0]       acc_q, acc_d;
    logic [MV_W-1:0]        mv_q, mv_d;
    logic [BCD_W-1:0]       shift_q, shift_d;
    logic [BCD_W-1:0]       bcd_q, bcd_d;
    logic                   bcd_valid_q, bcd_valid_d;

    logic [ACC_W-1:0]       acc_sum;
    logic [BCD_W-1:0]       dab_adj;
    logic [BCD_W+MV_W-1:0]  dab_next;
    logic                   load_en;
    logic [CODE_W-1:0]      load_code;
    logic                   unused_low;

    assign unused_low = ^adc_data[3:0];

`ifdef ADC_MV_BCD_PEND_EN
    logic              pend_q, pend_d;
    logic [CODE_W-1:0] pend_code_q, pend_code_d;

    // DONE always consumes the pending slot, either by loading it or by taking a fresher sample.
    always_comb begin
        pend_d      = pend_q;
        pend_code_d = pend_code_q;
        if (adc_valid && (state_q == MUL || state_q == DABBLE)) begin
            pend_d      = 1'b1;
            pend_code_d = adc_data[15:4];
        end else if (state_q == DONE) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            pend_q      <= 1'b0;
            pend_code_q <= '0;
        end else begin
            pend_q      <= pend_d;
            pend_code_q <= pend_code_d;
        end
    end

    assign adc_ready = 1'b1;
`else
    assign adc_ready = (state_q == IDLE);
`endif

    // Multiplicand walks left while the code walks right, so only bit 0 of the code is inspected.
    assign acc_sum = acc_q + (code_q[0] ? mcand_q : '0);

    for (genvar g = 0; g < 4; g++) begin : g_add3
        bcd_add3 u_add3 (
            .in  (shift_q[4*g +: 4]),
            .out (dab_adj[4*g +: 4])
        );
    end

    assign dab_next = {dab_adj, mv_q} << 1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        code_d      = code_q;
        mcand_d     = mcand_q;
        acc_d       = acc_q;
        mv_d        = mv_q;
        shift_d     = shift_q;
        bcd_d       = bcd_q;
        bcd_valid_d = 1'b0;
        load_en     = 1'b0;
        load_code   = adc_data[15:4];

        case (state_q)
            IDLE: begin
                if (adc_valid) begin
                    load_en = 1'b1;
                end
            end
            MUL: begin
                acc_d   = acc_sum;
                code_d  = code_q >> 1;
                mcand_d = mcand_q << 1;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(MUL_CYCLES - 1)) begin
                    state_d = DABBLE;
                    cnt_d   = '0;
                    mv_d    = acc_sum[ACC_W-1 -: MV_W];
                    shift_d = '0;
                end
            end
            DABBLE: begin
                shift_d = dab_next[BCD_W+MV_W-1 -: BCD_W];
                mv_d    = dab_next[MV_W-1:0];
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(DAB_CYCLES - 1)) begin
                    state_d     = DONE;
                    cnt_d       = '0;
                    bcd_d       = dab_next[BCD_W+MV_W-1 -: BCD_W];
                    bcd_valid_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
`ifdef ADC_MV_BCD_PEND_EN
                if (adc_valid) begin
                    load_en = 1'b1;
                end else if (pend_q) begin
                    load_en   = 1'b1;
                    load_code = pend_code_q;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        if (load_en) begin
            state_d = MUL;
            cnt_d   = '0;
            code_d  = load_code;
            mcand_d = FS_ACC;
            acc_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            code_q      <= '0;
            mcand_q     <= '0;
            acc_q       <= '0;
            mv_q        <= '0;
            shift_q     <= '0;
            bcd_q       <= '0;
            bcd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            code_q      <= code_d;
            mcand_q     <= mcand_d;
            acc_q       <= acc_d;
            mv_q        <= mv_d;
            shift_q     <= shift_d;
            bcd_q       <= bcd_d;
            bcd_valid_q <= bcd_valid_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign bcd       = bcd_q;
    assign bcd_valid = bcd_valid_q;

endmodule
